// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read/write control blocks.
//   state_t   : read-side output state (IDLE = no word held, HOLD = word held)
//   depth_of  : FIFO depth for a given RAM address width
//   ptr_diff  : modular difference of two pointers of width pw
package afifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned CALC_W = 32;

    // Depth helper used to derive DEPTH localparams from AWIDTH
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // (a - b) mod 2**pw; callers truncate the result to pw bits
    function automatic logic [CALC_W-1:0] ptr_diff(input logic [CALC_W-1:0] a,
                                                   input logic [CALC_W-1:0] b,
                                                   input int unsigned       pw);
        logic [CALC_W-1:0] mask;
        mask = (CALC_W'(1) << pw) - CALC_W'(1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/afifo_rdctl.sv
// Async FIFO read-side control (read clock domain).
// Takes the synchronised binary write pointer, issues RAM reads (1-cycle
// latency) and presents the RAM output as a first-word-fall-through stream.
// Ports:
//   clk, rst        read clock, async active-high reset
//   wptr            synchronised binary write pointer (AWIDTH+1 bits)
//   rptr            binary read pointer, flop output, steps by 0 or +1
//   raddr           RAM read address (rptr without wrap bit)
//   rden            RAM read enable
//   dout_valid      RAM output word valid for the consumer
//   dout_ready      consumer accepts the word
//   empty           no unread words beyond any held word
//   level           registered unread-word count (excludes held word)
//   err             sticky pointer-consistency error
//   almost_empty    only with AFIFO_RDCTL_ALMOST_EMPTY_EN (and AE_THRESH)
module afifo_rdctl
    import afifo_pkg::*;
#(
    parameter int unsigned AWIDTH    = 4
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
   ,parameter int unsigned AE_THRESH = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH:0]   wptr,
    output logic [AWIDTH:0]   rptr,
    output logic [AWIDTH-1:0] raddr,
    output logic              rden,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              empty,
    output logic [AWIDTH:0]   level,
    output logic              err
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
   ,output logic              almost_empty
`endif
);

    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned DEPTH = depth_of(AWIDTH);

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] diff;
    logic          err_cond;

    // Unread words in RAM, modular so wrap-around needs no special case
    assign diff     = PW'(ptr_diff(CALC_W'(wptr), CALC_W'(rptr), PW));
    assign empty    = (diff == '0);
    assign err_cond = (diff > DEPTH_P);

    assign raddr      = rptr[AWIDTH-1:0];
    assign dout_valid = (state == HOLD);
    assign rden       = !rst && !err && !empty && (!dout_valid || dout_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a read fills the output; a stalled consumer keeps it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rden) state_nxt = HOLD;
            end
            HOLD: begin
                if (dout_ready && !rden) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer, level and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            level <= '0;
            err   <= 1'b0;
        end else begin
            if (rden) rptr <= rptr + PW'(1);
            level <= diff - PW'(rden);
            if (err_cond) err <= 1'b1;
        end
    end

`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
    localparam logic [PW-1:0] AE_P = PW'(AE_THRESH);

    // Almost-empty flag, one clk behind diff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (diff <= AE_P);
        end
    end
`endif

endmodule

// File: tb/tb_afifo_rdctl.sv
// Directed bench for afifo_rdctl (AWIDTH=4, DEPTH=16).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// after a further settle delay, away from the edge.
module tb_afifo_rdctl;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          rden;
    logic          dout_valid;
    logic          dout_ready;
    logic          empty;
    logic [AW:0]   level;
    logic          err;
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
    logic          almost_empty;
`endif

    int checks   = 0;
    int failures = 0;

    afifo_rdctl #(
        .AWIDTH(AW)
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
       ,.AE_THRESH(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .wptr(wptr),
        .rptr(rptr),
        .raddr(raddr),
        .rden(rden),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .empty(empty),
        .level(level),
        .err(err)
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
       ,.almost_empty(almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        wptr       = 5'd5;
        dout_ready = 1'b1;
        settle();
        chk("rst_rden_forced", 32'(rden), 32'd0);
        chk("rst_dv", 32'(dout_valid), 32'd0);
        wptr = 5'd0;
        step();
        step();
        rst = 1'b0;
        settle();
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rden", 32'(rden), 32'd0);
        chk("rst_dv2", 32'(dout_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Three words, consumer always ready
        wptr = 5'd3;
        settle();
        chk("b3_rden0", 32'(rden), 32'd1);
        chk("b3_raddr0", 32'(raddr), 32'd0);
        chk("b3_dv0", 32'(dout_valid), 32'd0);
        step();
        chk("b3_rptr1", 32'(rptr), 32'd1);
        chk("b3_dv1", 32'(dout_valid), 32'd1);
        chk("b3_rden1", 32'(rden), 32'd1);
        chk("b3_raddr1", 32'(raddr), 32'd1);
        chk("b3_level1", 32'(level), 32'd2);
        step();
        chk("b3_dv2", 32'(dout_valid), 32'd1);
        chk("b3_rden2", 32'(rden), 32'd1);
        chk("b3_raddr2", 32'(raddr), 32'd2);
        chk("b3_level2", 32'(level), 32'd1);
        step();
        chk("b3_rptr3", 32'(rptr), 32'd3);
        chk("b3_empty", 32'(empty), 32'd1);
        chk("b3_dv3", 32'(dout_valid), 32'd1);
        chk("b3_rden3", 32'(rden), 32'd0);
        chk("b3_level3", 32'(level), 32'd0);
        step();
        chk("b3_dv_drop", 32'(dout_valid), 32'd0);

        // Full FIFO (16 words), consumer stalled
        dout_ready = 1'b0;
        wptr       = 5'd19;
        settle();
        chk("full_rden0", 32'(rden), 32'd1);
        chk("full_raddr0", 32'(raddr), 32'd3);
        step();
        chk("full_rptr", 32'(rptr), 32'd4);
        chk("full_dv", 32'(dout_valid), 32'd1);
        chk("full_rden_stall", 32'(rden), 32'd0);
        chk("full_level", 32'(level), 32'd15);
        step();
        chk("full_rptr_hold", 32'(rptr), 32'd4);
        chk("full_rden_stall2", 32'(rden), 32'd0);
        chk("full_level2", 32'(level), 32'd15);
        chk("full_err", 32'(err), 32'd0);
        dout_ready = 1'b1;
        settle();
        for (int i = 0; i < 15; i++) begin
            chk("drain_rden", 32'(rden), 32'd1);
            chk("drain_raddr", 32'(raddr), 32'((4 + i) % 16));
            chk("drain_dv", 32'(dout_valid), 32'd1);
            step();
        end
        chk("drain_rptr", 32'(rptr), 32'd19);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rden_end", 32'(rden), 32'd0);
        chk("drain_dv_last", 32'(dout_valid), 32'd1);
        step();
        chk("drain_dv_idle", 32'(dout_valid), 32'd0);

        // Advance to rptr=30, then wrap with wptr=2 (diff 4)
        wptr = 5'd30;
        settle();
        for (int i = 0; i < 11; i++) step();
        chk("pre_wrap_rptr", 32'(rptr), 32'd30);
        chk("pre_wrap_empty", 32'(empty), 32'd1);
        wptr = 5'd2;
        settle();
        chk("wrap_rden", 32'(rden), 32'd1);
        chk("wrap_raddr", 32'(raddr), 32'd14);
        step();
        chk("wrap_rptr31", 32'(rptr), 32'd31);
        chk("wrap_level", 32'(level), 32'd3);
        step();
        chk("wrap_rptr0", 32'(rptr), 32'd0);
        step();
        chk("wrap_rptr1", 32'(rptr), 32'd1);
        step();
        chk("wrap_rptr2", 32'(rptr), 32'd2);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_err", 32'(err), 32'd0);
        chk("wrap_dv", 32'(dout_valid), 32'd1);

        // Impossible diff of 17 while a word is held and stalled
        dout_ready = 1'b0;
        settle();
        wptr = 5'd19;
        settle();
        chk("err_pre_rden", 32'(rden), 32'd0);
        chk("err_pre_err", 32'(err), 32'd0);
        step();
        chk("err_set", 32'(err), 32'd1);
        chk("err_rden", 32'(rden), 32'd0);
        chk("err_dv_held", 32'(dout_valid), 32'd1);
        chk("err_level", 32'(level), 32'd17);
        dout_ready = 1'b1;
        settle();
        chk("err_rden_ready", 32'(rden), 32'd0);
        step();
        chk("err_held_consumed", 32'(dout_valid), 32'd0);
        chk("err_rptr_frozen", 32'(rptr), 32'd2);
        step();
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_rptr_frozen2", 32'(rptr), 32'd2);

        // Reset clears the error
        rst  = 1'b1;
        wptr = 5'd0;
        step();
        rst = 1'b0;
        settle();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_rst_rptr", 32'(rptr), 32'd0);

        // Reset mid-transfer drops the held word asynchronously
        dout_ready = 1'b0;
        wptr       = 5'd1;
        settle();
        step();
        chk("mid_dv", 32'(dout_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_dv_async", 32'(dout_valid), 32'd0);
        chk("mid_rden", 32'(rden), 32'd0);
        chk("mid_rptr", 32'(rptr), 32'd0);
        wptr = 5'd0;
        step();
`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
        chk("ae_rst", 32'(almost_empty), 32'd1);
`endif
        rst = 1'b0;
        settle();
        chk("mid_post_err", 32'(err), 32'd0);

`ifdef AFIFO_RDCTL_ALMOST_EMPTY_EN
        // diff 3 -> flag low; one read later diff 2 -> flag high
        wptr = 5'd3;
        settle();
        step();
        chk("ae_diff3", 32'(almost_empty), 32'd0);
        chk("ae_rptr1", 32'(rptr), 32'd1);
        step();
        chk("ae_diff2", 32'(almost_empty), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
